// File: rtl/cache_fill_ctrl_if.sv
// CPU request, memory fetch and cache-array ports of cache_fill_ctrl.
// master is the controller side; slave is the requester/memory/array side.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic [1:0]        rdline;
    logic [2:0]        rdoffset;
    logic [1:0]        wrline;
    logic [2:0]        wroffset;
    logic [7:0]        wdata;
    logic              wren;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (
        input  cpu_req, cpu_addr, mem_ack, mem_data,
        output cpu_ack, rdline, rdoffset, wrline, wroffset, wdata, wren,
               mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, mem_ack, mem_data,
        input  cpu_ack, rdline, rdoffset, wrline, wroffset, wdata, wren,
               mem_req, mem_addr
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Tag/valid lookup plus byte-serial line fill for a 4x8-byte cache array; hit acks in RESP right
// after the request edge, a miss fills 8 bytes first. mem_ack low stalls the fill indefinitely.
module cache_fill_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    cache_fill_ctrl_if.master bus
);
    localparam int TAG_W = ADDR_W - 5;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                     state, state_nxt;
    logic [ADDR_W-1:0]          addr_q;
    logic [2:0]                 fill_cnt;
    logic [3:0]                 valid;
    logic [3:0][TAG_W-1:0]      tags;
    logic                       wren_q;
    logic [7:0]                 wdata_q;
    logic [1:0]                 wrline_q;
    logic [2:0]                 wroffset_q;

    logic [1:0]                 req_line;
    logic [TAG_W-1:0]           req_tag;
    logic [1:0]                 cur_line;
    logic                       accept, hit, byte_ack, fill_done;

    assign req_line = bus.cpu_addr[4:3];
    assign req_tag  = bus.cpu_addr[ADDR_W-1:5];
    assign cur_line = addr_q[4:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hit       = 1'b0;
        byte_ack  = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    accept    = 1'b1;
                    hit       = valid[req_line] && (tags[req_line] == req_tag);
                    state_nxt = hit ? RESP : FILL;
                end
            end
            FILL: begin
                if (bus.mem_ack) begin
                    byte_ack = 1'b1;
                    if (fill_cnt == 3'd7) begin
                        fill_done = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            fill_cnt   <= '0;
            valid      <= '0;
            tags       <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            wrline_q   <= '0;
            wroffset_q <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            wren_q <= byte_ack;
            if (accept) begin
                addr_q   <= bus.cpu_addr;
                fill_cnt <= '0;
            end
            if (accept && hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (accept && !hit && (miss_cnt != '1))
                miss_cnt <= miss_cnt + CNT_W'(1);
            if (byte_ack) begin
                wdata_q    <= bus.mem_data;
                wrline_q   <= cur_line;
                wroffset_q <= fill_cnt;
                fill_cnt   <= fill_cnt + 3'd1;
            end
            // The fill-complete set is written after the flush clear so it wins on a shared edge.
            if (flush)
                valid <= '0;
            if (fill_done) begin
                valid[cur_line] <= 1'b1;
                tags[cur_line]  <= addr_q[ADDR_W-1:5];
            end
        end
    end

    assign bus.cpu_ack  = (state == RESP);
    assign bus.mem_req  = (state == FILL);
    assign bus.mem_addr = (state == FILL) ? {addr_q[ADDR_W-1:3], fill_cnt} : '0;
    assign bus.rdline   = addr_q[4:3];
    assign bus.rdoffset = addr_q[2:0];
    assign bus.wren     = wren_q;
    assign bus.wdata    = wdata_q;
    assign bus.wrline   = wrline_q;
    assign bus.wroffset = wroffset_q;
endmodule
